// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin grant controller.
package arb_pkg;

  localparam int STATE_W = 2;
  localparam int N_DEF   = 8;
  localparam int LW_DEF  = 4;
  localparam int CW_DEF  = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_e;

endpackage

// File: rtl/arb_grant_ctrl_onehot_next.sv
// Maps a requester index to the one-hot position of the next requester (wraps N-1 -> 0).
module onehot_next #(
  parameter int N = 8
) (
  input  logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         onehot
);

  localparam int IW = $clog2(N);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == idx) onehot[(i + 1) % N] = 1'b1;
    end
  end

endmodule

// File: rtl/arb_grant_ctrl.sv
// Upstream responder for a one-hot-priority arbiter chain: grants the resource for a
// programmable length, latches the winner, then rotates priority past it.
module arb_grant_ctrl
  import arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int LW = LW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 req,
  input  logic [N-1:0]         grant_vec,
  input  logic [LW-1:0]        len,
  output logic                 ack,
  output logic [N-1:0]         prio,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        grant_count,
  output logic                 err
);

  localparam int IW = $clog2(N);

  state_e        state;
  logic [LW-1:0] len_cnt;
  logic [IW-1:0] low_idx;
  logic          multi_hot;
  logic [N-1:0]  prio_next;

  // Lowest set bit wins when the chain reports more than one acknowledge.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (grant_vec[i]) low_idx = IW'(i);
    end
  end

  assign multi_hot = |(grant_vec & (grant_vec - N'(1)));

  onehot_next #(.N(N)) u_onehot_next (
    .idx    (owner),
    .onehot (prio_next)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      ack         <= 1'b0;
      prio        <= N'(1);
      owner       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      grant_count <= '0;
      err         <= 1'b0;
      len_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && req) begin
            state <= GRANT;
            ack   <= 1'b1;
          end
        end

        GRANT: begin
          ack <= 1'b0;
          if (grant_vec == '0) begin
            state <= IDLE;
          end else begin
            owner   <= low_idx;
            len_cnt <= (len == '0) ? LW'(1) : len;
            busy    <= 1'b1;
            done    <= (len <= LW'(1));
            state   <= BUSY;
            if (multi_hot) err <= 1'b1;
          end
        end

        BUSY: begin
          if (len_cnt == LW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            prio  <= prio_next;
            state <= IDLE;
            if (~&grant_count) grant_count <= grant_count + CW'(1);
          end else begin
            len_cnt <= len_cnt - LW'(1);
            // done is registered, so raise it one cycle ahead of the final count.
            done    <= (len_cnt == LW'(2));
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// Directed scoreboard bench for arb_grant_ctrl; a second CW=2 instance exercises saturation.
module tb_arb_grant_ctrl;

  localparam int N  = 8;
  localparam int LW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic          req = 1'b0;
  logic [N-1:0]  grant_vec = '0;
  logic [LW-1:0] len = '0;

  logic          ack, busy, done, err;
  logic [N-1:0]  prio;
  logic [2:0]    owner;
  logic [CW-1:0] grant_count;

  logic          ack_s, busy_s, done_s, err_s;
  logic [N-1:0]  prio_s;
  logic [2:0]    owner_s;
  logic [1:0]    grant_count_s;

  arb_grant_ctrl #(.N(N), .LW(LW), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .req(req), .grant_vec(grant_vec), .len(len),
    .ack(ack), .prio(prio), .owner(owner), .busy(busy), .done(done),
    .grant_count(grant_count), .err(err)
  );

  arb_grant_ctrl #(.N(N), .LW(LW), .CW(2)) u_sat (
    .clk(clk), .rstn(rstn), .enable(enable), .req(req), .grant_vec(grant_vec), .len(len),
    .ack(ack_s), .prio(prio_s), .owner(owner_s), .busy(busy_s), .done(done_s),
    .grant_count(grant_count_s), .err(err_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    owner;
    logic [N-1:0]  prio;
    logic [CW-1:0] cnt;
    logic [1:0]    sat;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  logic [N-1:0]  m_prio = N'(1);
  logic [CW-1:0] m_cnt = '0;
  logic [1:0]    m_sat = '0;
  logic          m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request/grant handshake; drop_at > 0 lowers enable in that busy cycle.
  task automatic txn(input logic [N-1:0] gv, input logic [LW-1:0] ln, input int drop_at);
    logic [2:0] own;
    int         cyc;
    bit         seen;
    exp_t       e;
    exp_t       got;
    enable    = 1'b1;
    req       = 1'b1;
    grant_vec = gv;
    len       = ln;
    step();
    check("grant_ack", ack, 1);
    check("grant_busy", busy, 0);
    step();
    req = 1'b0;
    if (gv == '0) begin
      check("wd_ack", ack, 0);
      check("wd_busy", busy, 0);
      check("wd_prio", prio, m_prio);
      check("wd_count", grant_count, m_cnt);
      step();
      check("wd_idle_busy", busy, 0);
      return;
    end
    own = '0;
    for (int i = N - 1; i >= 0; i--) if (gv[i]) own = 3'(i);
    if ($countones(gv) > 1) m_err = 1'b1;
    if (int'(own) == N - 1) m_prio = N'(1);
    else                    m_prio = N'(1) << (int'(own) + 1);
    if (m_cnt != '1) m_cnt = m_cnt + CW'(1);
    if (m_sat != '1) m_sat = m_sat + 2'd1;
    e.owner = own;
    e.prio  = m_prio;
    e.cnt   = m_cnt;
    e.sat   = m_sat;
    e.cyc   = (ln == '0) ? 1 : int'(ln);
    sb.push_back(e);
    cyc  = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check("busy_hi", busy, 1);
      check("busy_ack", ack, 0);
      cyc++;
      if (cyc == drop_at) enable = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    got = sb.pop_front();
    if (!seen) begin
      total++;
      bad++;
      $error("FAIL done_timeout: observed=no_done expected=done_within_40");
    end
    check("busy_len", cyc, got.cyc);
    check("owner", owner, got.owner);
    check("prio_hold", prio, prio_s);
    step();
    check("after_busy", busy, 0);
    check("after_done", done, 0);
    check("prio", prio, got.prio);
    check("count", grant_count, got.cnt);
    check("sat_count", grant_count_s, got.sat);
    check("err", err, m_err);
  endtask

  initial begin
    // Start a transaction, then reset mid-way: it must be abandoned cleanly.
    step();
    rstn = 1'b1;
    enable = 1'b1; req = 1'b1; grant_vec = 8'b0000_0001; len = 4'd4;
    step(); step(); step();
    rstn = 1'b0; req = 1'b0;
    step();
    check("rst_prio", prio, 8'b0000_0001);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", grant_count, 0);
    check("rst_err", err, 0);
    check("rst_owner", owner, 0);
    rstn = 1'b1;
    step();
    check("post_rst_ack", ack, 0);

    txn(8'b0000_0100, 4'd3, 0);   // single grant, owner 2
    txn(8'b1000_0000, 4'd0, 0);   // wrap, len 0 behaves as 1
    txn(8'b0000_0000, 4'd2, 0);   // request withdrawn
    txn(8'b0011_0000, 4'd2, 0);   // multi-hot, lowest wins
    txn(8'b0000_0001, 4'd5, 2);   // enable drops mid-busy

    req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("blocked_ack", ack, 0);
      check("blocked_busy", busy, 0);
    end
    req = 1'b0;
    check("final_err", err, 1);
    check("final_count", grant_count, 4);
    check("final_sat", grant_count_s, 3);
    check("final_prio", prio, 8'b0000_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
